// File: rtl/eeprom_selftest_pkg.sv
// Shared types and helpers for the EEPROM write/read-back self-test sequencer.
package eeprom_selftest_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        WR_REQ,
        WR_RSP,
        WR_GAP,
        RD_REQ,
        RD_RSP,
        FINISH
    } state_t;

    localparam logic CMD_WR = 1'b0;
    localparam logic CMD_RD = 1'b1;

    function automatic logic [7:0] pattern_byte(input logic [7:0] idx, input logic [7:0] pattern);
        return pattern ^ idx;
    endfunction

endpackage

// File: rtl/eeprom_selftest_delay_cnt.sv
// 20-bit load/expire down-counter used for the power-up, tWR and retry waits.
module eeprom_selftest_delay_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] load_val,
    output logic        expired
);
    logic [19:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 20'd1;
        end
    end

    // A load in flight masks the stale zero left over from the previous wait.
    assign expired = (cnt == '0) && !load;

endmodule

// File: rtl/eeprom_selftest.sv
// EEPROM self-test: writes NUM_BYTES pattern bytes, waits tWR, reads back and compares.
// Optional NACK retry with busy-polling delay is enabled by EEPROM_SELFTEST_RETRY_EN.
module eeprom_selftest
    import eeprom_selftest_pkg::*;
#(
    parameter int          NUM_BYTES  = 8,
    parameter logic [15:0] START_ADDR = 16'h0000,
    parameter logic [7:0]  PATTERN    = 8'hA5,
    parameter logic [19:0] INIT_DLY   = 20'd500_000,
    parameter logic [19:0] WR_WAIT    = 20'd250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        cmd_rw,
    output logic [15:0] cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic        rsp_done,
    input  logic        rsp_nack,
    input  logic [7:0]  rsp_rdata,
    output logic        done,
    output logic        flag,
    output logic [2:0]  dbg_state
);
    localparam logic [7:0] LAST_IDX = 8'(NUM_BYTES - 1);

    state_t      state;
    logic [7:0]  idx;
    logic        err;
    logic        armed;
    logic        start_q;
    logic        dly_load;
    logic        dly_expired;
    logic        rd_bad;
    logic [19:0] dly_val;
`ifdef EEPROM_SELFTEST_RETRY_EN
    logic [1:0]  retry_cnt;
    logic        rty_pend;
    logic        rty_rd;
`endif

    // cmd handshake: a command is taken on the cycle where cmd_valid & cmd_ready;
    // cmd_* stay frozen while cmd_valid is high and unanswered.
    assign dly_load  = (state == INIT || state == WR_GAP) && !armed;
    assign dly_val   = (state == INIT) ? INIT_DLY : WR_WAIT;
    assign rd_bad    = rsp_nack || (rsp_rdata != pattern_byte(idx, PATTERN));
    assign dbg_state = state;

    eeprom_selftest_delay_cnt u_dly (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (dly_val),
        .expired  (dly_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            idx       <= '0;
            err       <= 1'b0;
            armed     <= 1'b0;
            start_q   <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_rw    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            done      <= 1'b0;
            flag      <= 1'b0;
`ifdef EEPROM_SELFTEST_RETRY_EN
            retry_cnt <= '0;
            rty_pend  <= 1'b0;
            rty_rd    <= 1'b0;
`endif
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                INIT: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (dly_expired) begin
                        armed <= 1'b0;
                        state <= WR_REQ;
                    end
                end
                IDLE: begin
                    if (start && !start_q) begin
                        err   <= 1'b0;
                        idx   <= '0;
                        state <= WR_REQ;
`ifdef EEPROM_SELFTEST_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                WR_REQ, RD_REQ: begin
                    // First cycle in the state loads the command, later cycles wait for ready.
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd_rw    <= (state == RD_REQ) ? CMD_RD : CMD_WR;
                        cmd_addr  <= START_ADDR + 16'(idx);
                        cmd_wdata <= (state == RD_REQ) ? 8'h00 : pattern_byte(idx, PATTERN);
                    end else if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= (state == RD_REQ) ? RD_RSP : WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (rsp_done) begin
                        if (rsp_nack) begin
`ifdef EEPROM_SELFTEST_RETRY_EN
                            if (retry_cnt != 2'd3) begin
                                retry_cnt <= retry_cnt + 2'd1;
                                rty_pend  <= 1'b1;
                                rty_rd    <= 1'b0;
                                state     <= WR_GAP;
                            end else
`endif
                            begin
                                err   <= 1'b1;
                                done  <= 1'b1;
                                flag  <= 1'b1;
                                state <= FINISH;
                            end
                        end else begin
`ifdef EEPROM_SELFTEST_RETRY_EN
                            retry_cnt <= '0;
`endif
                            if (idx == LAST_IDX) begin
                                idx   <= '0;
                                state <= WR_GAP;
                            end else begin
                                idx   <= idx + 8'd1;
                                state <= WR_REQ;
                            end
                        end
                    end
                end
                WR_GAP: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (dly_expired) begin
                        armed <= 1'b0;
`ifdef EEPROM_SELFTEST_RETRY_EN
                        if (rty_pend) begin
                            rty_pend <= 1'b0;
                            state    <= rty_rd ? RD_REQ : WR_REQ;
                        end else
`endif
                        state <= RD_REQ;
                    end
                end
                RD_RSP: begin
                    if (rsp_done) begin
`ifdef EEPROM_SELFTEST_RETRY_EN
                        if (rsp_nack && retry_cnt != 2'd3) begin
                            retry_cnt <= retry_cnt + 2'd1;
                            rty_pend  <= 1'b1;
                            rty_rd    <= 1'b1;
                            state     <= WR_GAP;
                        end else
`endif
                        begin
`ifdef EEPROM_SELFTEST_RETRY_EN
                            retry_cnt <= '0;
`endif
                            if (rd_bad) err <= 1'b1;
                            // done is raised here so it lands one cycle after the last response.
                            if (idx == LAST_IDX) begin
                                done  <= 1'b1;
                                flag  <= err | rd_bad;
                                state <= FINISH;
                            end else begin
                                idx   <= idx + 8'd1;
                                state <= RD_REQ;
                            end
                        end
                    end
                end
                FINISH:  state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end

endmodule
